alu_op_sequencer: RTL and testbench

//  Front-end controller for the ALU datapath. Accepts one command (opcode + two 8-bit operands)
//  per valid/ready handshake, then sequences it: operand-register load, ALU start, optional

---
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ALU front-end sequencer: accepts one command per handshake and steps it
// through operand load, ALU start, optional wait, writeback and response.
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W = 4,
  parameter logic [(1<<OP_W)-1:0] LEGAL_MASK = '1,
  parameter logic [(1<<OP_W)-1:0] MULTI_MASK = 16'hF000,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              a_load,
  output logic              b_load,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  output logic              out_load,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WAIT,
    S_WB,
    S_RESP
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              err_q, err_d;
  logic [7:0]        timer_q, timer_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    timer_d = timer_q;
    unique case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          err_d   = !LEGAL_MASK[cmd_op];
          state_d = LEGAL_MASK[cmd_op] ? S_LOAD : S_RESP;
        end
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: begin
        timer_d = '0;
        state_d = MULTI_MASK[op_q] ? S_WAIT : S_WB;
      end
      S_WAIT: begin
        // done beats a timeout landing on the same cycle
        if (alu_done) begin
          state_d = S_WB;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_WB:   state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign a_load    = (state_q == S_LOAD);
  assign b_load    = (state_q == S_LOAD);
  assign a_data    = a_q;
  assign b_data    = b_q;
  assign alu_op    = op_q;
  assign alu_start = (state_q == S_EXEC);
  assign out_load  = (state_q == S_WB);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) && err_q;
  // INIT is a reset-recovery slot, not work in progress
  assign busy      = (state_q != S_IDLE) && (state_q != S_INIT);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: vector table driven through a scoreboard,
// plus hand sequences for reset, response back-pressure and mid-op reset.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       a_load, b_load;
  logic [7:0] a_data, b_data;
  logic [3:0] alu_op;
  logic       alu_start;
  logic       alu_done = 1'b0;
  logic       out_load;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_err;
  logic       busy;

  alu_op_sequencer #(
    .DATA_W(8),
    .OP_W(4),
    .LEGAL_MASK(16'hFFDF),
    .MULTI_MASK(16'hF000),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .a_load(a_load),
    .b_load(b_load),
    .a_data(a_data),
    .b_data(b_data),
    .alu_op(alu_op),
    .alu_start(alu_start),
    .alu_done(alu_done),
    .out_load(out_load),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         done_d;
    bit         err;
    int         wb_c;
    int         rsp_c;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    bit         err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(cmd_ready), 1);
  endtask

  task automatic accept(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit err);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    @(posedge clk);
    sb.push_back('{op, a, b, err});
    @(negedge clk);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check(name, 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int la_c = 0;
    int st_c = 0;
    int wb_c = 0;
    int wbn = 0;
    int rsp_c = 0;
    bit legal = !v.err || v.wb_c != 0 || v.rsp_c != 1;
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_ready();
    accept(v.op, v.a, v.b, v.err);
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom);
    cmd_a = 8'($urandom);
    cmd_b = 8'($urandom);
    for (int c = 1; c <= 40 && rsp_c == 0; c++) begin
      if (a_load && la_c == 0) begin
        la_c = c;
        check({tag, "_b_load"}, 32'(b_load), 1);
        check({tag, "_a_data"}, 32'(a_data), 32'(sb[0].a));
        check({tag, "_b_data"}, 32'(b_data), 32'(sb[0].b));
        check({tag, "_alu_op"}, 32'(alu_op), 32'(sb[0].op));
      end
      if (alu_start && st_c == 0) st_c = c;
      if (out_load) begin
        wbn++;
        if (wb_c == 0) wb_c = c;
      end
      if (rsp_valid) begin
        rsp_c = c;
        pop_check({tag, "_err"});
      end
      alu_done = (v.done_d >= 0 && c == 2 + v.done_d);
      if (rsp_c == 0) @(negedge clk);
    end
    alu_done = 1'b0;
    check({tag, "_load_cyc"}, 32'(la_c), legal ? 1 : 0);
    check({tag, "_start_cyc"}, 32'(st_c), legal ? 2 : 0);
    check({tag, "_wb_cyc"}, 32'(wb_c), 32'(v.wb_c));
    check({tag, "_wb_cnt"}, 32'(wbn), v.wb_c != 0 ? 1 : 0);
    check({tag, "_rsp_cyc"}, 32'(rsp_c), 32'(v.rsp_c));
    @(negedge clk);
    check({tag, "_idle_hold"}, {alu_op, a_data, b_data, 3'b0, cmd_ready},
          {v.op, v.a, v.b, 4'b0001});
  endtask

  task automatic check_all_zero(input string name);
    check(name, {cmd_ready, a_load, b_load, a_data, b_data, alu_op,
                 alu_start, out_load, rsp_valid, rsp_err, busy}, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h0, 8'h12, 8'h34, -1, 1'b0, 3, 4};
    vecs[1] = '{4'h3, 8'hA5, 8'h5A, -1, 1'b0, 3, 4};
    vecs[2] = '{4'hC, 8'h01, 8'h02, 3, 1'b0, 6, 7};
    vecs[3] = '{4'hC, 8'hFF, 8'h00, -1, 1'b1, 0, 18};
    vecs[4] = '{4'h5, 8'h77, 8'h88, -1, 1'b1, 0, 1};
    vecs[5] = '{4'hF, 8'h3C, 8'hC3, 1, 1'b0, 4, 5};
    vecs[6] = '{4'hD, 8'h10, 8'h20, 15, 1'b0, 18, 19};
    vecs[7] = '{4'hD, 8'h30, 8'h40, 16, 1'b1, 0, 18};
    vecs[8] = '{4'h4, 8'h9E, 8'hE9, -1, 1'b0, 3, 4};

    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    #1;
    check("init_not_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    check("idle_ready", 32'(cmd_ready), 1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    rsp_ready = 1'b0;
    wait_ready();
    accept(4'h0, 8'h11, 8'h22, 1'b0);
    cmd_valid = 1'b0;
    for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
    check("hold_rsp_seen", 32'(rsp_valid), 1);
    pop_check("hold_err");
    cmd_valid = 1'b1;
    cmd_op = 4'hC;
    cmd_a = 8'h66;
    cmd_b = 8'h77;
    repeat (5) begin
      @(negedge clk);
      check("hold_state", {rsp_valid, cmd_ready, a_load, busy}, 4'b1001);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_back_idle", {cmd_ready, rsp_valid}, 2'b10);
    @(posedge clk);
    sb.push_back('{4'hC, 8'h66, 8'h77, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    check("next_load", {a_load, a_data, b_data}, {1'b1, 8'h66, 8'h77});
    repeat (2) @(negedge clk);
    check("in_wait", {busy, alu_start, out_load, rsp_valid}, 4'b1000);
    reset_n = 1'b0;
    #1;
    check_all_zero("midop_reset");
    sb.delete();
    @(negedge clk);
    check_all_zero("midop_reset_held");
    reset_n = 1'b1;
    #1;
    check("reinit_not_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    check("reinit_ready", 32'(cmd_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
